// File: rtl/cla_pipe_addsub_if.sv
// Operand/result stream bundle for cla_pipe_addsub.
// Carries the optional zero flag when CLA_PIPE_ZERO_EN is defined.
interface cla_pipe_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef CLA_PIPE_ZERO_EN
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor, one GROUP-bit CLA block per stage.
// Define CLA_PIPE_ZERO_EN to add a registered zero-result flag.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / GROUP;

    // Global stall: every stage shifts together or none does.
    logic adv;
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned LO   = k * GROUP;
        localparam int unsigned REM  = WIDTH - LO;
        localparam int unsigned DONE = LO + GROUP;

        logic [REM-1:0]   a_i;
        logic [REM-1:0]   b_i;
        logic             c_i;
        logic             v_i;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic [GROUP-1:0] s_g;
        logic [DONE-1:0]  s_n;
        logic             acc;
        logic             prod;

        logic             v_q;
        logic             c_q;
        logic [DONE-1:0]  s_q;

        // Mode is resolved once here; later stages only see the effective operand.
        if (k == 0) begin : g_entry
            assign a_i = bus.a;
            assign b_i = bus.sub ? ~bus.b : bus.b;
            assign c_i = bus.sub | bus.cin;
            assign v_i = bus.in_valid;
            assign s_n = s_g;
        end else begin : g_mid
            assign a_i = g_stg[k-1].g_ops.a_q;
            assign b_i = g_stg[k-1].g_ops.b_q;
            assign c_i = g_stg[k-1].c_q;
            assign v_i = g_stg[k-1].v_q;
            assign s_n = {s_g, g_stg[k-1].s_q};
        end

        assign g = a_i[GROUP-1:0] & b_i[GROUP-1:0];
        assign p = a_i[GROUP-1:0] ^ b_i[GROUP-1:0];

        // Two-level lookahead: c[i+1] = cin&P[i:0] | OR_j (g[j] & P[i:j+1]).
        always_comb begin
            c    = '0;
            acc  = 1'b0;
            prod = 1'b0;
            c[0] = c_i;
            for (int i = 0; i < int'(GROUP); i++) begin
                acc = c_i;
                for (int j = 0; j <= i; j++) acc = acc & p[j];
                for (int j = 0; j <= i; j++) begin
                    prod = g[j];
                    for (int m = j + 1; m <= i; m++) prod = prod & p[m];
                    acc = acc | prod;
                end
                c[i+1] = acc;
            end
        end

        assign s_g = p ^ c[GROUP-1:0];

        // Bubbles load zeros so nothing stale reaches the outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_i;
                c_q <= v_i & c[GROUP];
                s_q <= v_i ? s_n : '0;
            end
        end

        if (k + 1 < STAGES) begin : g_ops
            logic [REM-GROUP-1:0] a_q;
            logic [REM-GROUP-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_i[REM-1:GROUP];
                    b_q <= b_i[REM-1:GROUP];
                end
            end
        end

        if (k + 1 == STAGES) begin : g_exit
            logic ovf_q;
`ifdef CLA_PIPE_ZERO_EN
            logic zero_q;
`endif

            // Overflow from the carries into and out of the MSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
`ifdef CLA_PIPE_ZERO_EN
                    zero_q <= 1'b0;
`endif
                end else if (adv) begin
                    ovf_q  <= v_i & (c[GROUP] ^ c[GROUP-1]);
`ifdef CLA_PIPE_ZERO_EN
                    zero_q <= v_i & (s_n == '0);
`endif
                end
            end
        end
    end

    assign bus.out_valid = g_stg[STAGES-1].v_q;
    assign bus.sum       = g_stg[STAGES-1].s_q;
    assign bus.cout      = g_stg[STAGES-1].c_q;
    assign bus.ovf       = g_stg[STAGES-1].g_exit.ovf_q;
`ifdef CLA_PIPE_ZERO_EN
    assign bus.zero      = g_stg[STAGES-1].g_exit.zero_q;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: directed table, backpressure, reset, random, alt widths.
// Checks the zero flag as well when CLA_PIPE_ZERO_EN is defined.
module tb_cla_pipe_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(16)) bus ();
    cla_pipe_addsub_if #(.WIDTH(8))  bus8 ();
    cla_pipe_addsub_if #(.WIDTH(32)) bus32 ();

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
    cla_pipe_addsub #(.WIDTH(8),  .GROUP(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    cla_pipe_addsub #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   n_stall  = 0;
    res_t expq[$];
    logic stall_prev = 1'b0;
    res_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        logic [15:0] bp;
        int          ce;
        int          u;
        int          s;
        res_t        r;
        bp     = sub ? ~b : b;
        ce     = (sub || cin) ? 1 : 0;
        u      = int'(a) + int'(bp) + ce;
        s      = int'($signed(a)) + int'($signed(bp)) + ce;
        r.sum  = u[15:0];
        r.cout = u[16];
        r.ovf  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    // Scoreboard and stall monitor on the 16/4 instance.
    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (stall_prev) begin
                chk("stall_hold_valid", 64'(bus.out_valid), 64'(1));
                chk("stall_hold_data", 64'({bus.sum, bus.cout, bus.ovf}), 64'(held));
            end
            if (bus.out_valid && !bus.out_ready) begin
                n_stall <= n_stall + 1;
                chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out <= n_out + 1;
                if (expq.size() == 0) begin
                    chk("unexpected_result", 64'(bus.out_valid), 64'(0));
                end else begin
                    e = expq.pop_front();
                    chk("result", 64'({bus.sum, bus.cout, bus.ovf}), 64'(e));
`ifdef CLA_PIPE_ZERO_EN
                    chk("result_zero", 64'(bus.zero), 64'(e.sum == 16'h0));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            stall_prev <= bus.out_valid && !bus.out_ready;
            held       <= {bus.sum, bus.cout, bus.ovf};
        end else begin
            stall_prev <= 1'b0;
        end
    end

    // One beat into an empty pipe with out_ready=1; checks latency and the table value.
    task automatic directed(input int idx, input vec_t v);
        int lat;
        @(posedge clk); #1;
        bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.sub = v.sub; bus.in_valid = 1'b1;
        chk($sformatf("vec%0d_in_ready", idx), 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'(4));
        chk($sformatf("vec%0d_sum", idx), 64'(bus.sum), 64'(v.sum));
        chk($sformatf("vec%0d_cout", idx), 64'(bus.cout), 64'(v.cout));
        chk($sformatf("vec%0d_ovf", idx), 64'(bus.ovf), 64'(v.ovf));
`ifdef CLA_PIPE_ZERO_EN
        chk($sformatf("vec%0d_zero", idx), 64'(bus.zero), 64'(v.sum == 16'h0));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t vr;
        int   lat;
        int   out0;
        int   st0;
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h55AA, 16'hAA55, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h6C6C, 16'hCACA, 1'b1, 1'b0, 16'h3737, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_outputs", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
        chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef CLA_PIPE_ZERO_EN
        chk("reset_zero", 64'(bus.zero), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 9; i++) directed(i, vecs[i]);

        // Backpressure: six back-to-back beats, three stalled cycles mid-stream.
        repeat (3) @(posedge clk);
        #1;
        out0 = n_out;
        st0  = n_stall;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic acc;
                    int   tries;
                    bus.a = 16'(i * 16'h1111 + 3);
                    bus.b = 16'(16'h0F0F ^ (i * 16'h0123));
                    bus.cin = i[1];
                    bus.sub = i[0];
                    bus.in_valid = 1'b1;
                    tries = 0;
                    do begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        @(posedge clk); #1;
                        tries++;
                    end while (!acc && tries < 50);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        chk("bp_results", 64'(n_out - out0), 64'(6));
        chk("bp_stall_cycles", 64'(n_stall - st0), 64'(3));
        chk("bp_drained", 64'(expq.size()), 64'(0));

        // Reset mid-flight with the head result stalled at the output.
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 16'h4321;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rst_pre_valid", 64'(bus.out_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_async_outputs", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
        chk("rst_async_in_ready", 64'(bus.in_ready), 64'(1));
        expq.delete();
        #10;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_no_ghost%0d", i), 64'(bus.out_valid), 64'(0));
        end
        vr = '{16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        directed(9, vr);

        // Randomised stream against the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = 16'($urandom);
            bus.b         = 16'($urandom);
            bus.cin       = 1'($urandom);
            bus.sub       = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_drained", 64'(expq.size()), 64'(0));

        // Single-stage configuration (8/8).
        @(posedge clk); #1;
        bus8.a = 8'hFF; bus8.b = 8'h01; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'(1));
        chk("w8_result", 64'({bus8.sum, bus8.cout, bus8.ovf}), 64'({8'h00, 1'b1, 1'b0}));
`ifdef CLA_PIPE_ZERO_EN
        chk("w8_zero", 64'(bus8.zero), 64'(1));
`endif

        // Wide configuration (32/8), add then subtract.
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            bus32.a   = (t == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            bus32.b   = 32'h0000_0001;
            bus32.sub = (t == 1);
            bus32.in_valid = 1'b1;
            @(posedge clk); #1;
            bus32.in_valid = 1'b0;
            lat = 1;
            while (!bus32.out_valid && lat < 16) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("w32_latency%0d", t), 64'(lat), 64'(4));
            if (t == 0)
                chk("w32_add", 64'({bus32.sum, bus32.cout, bus32.ovf}), 64'({32'h0000_0000, 1'b1, 1'b0}));
            else
                chk("w32_sub", 64'({bus32.sum, bus32.cout, bus32.ovf}), 64'({32'hFFFF_FFFF, 1'b0, 1'b0}));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
